bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for cache block transfers: one owner at a time,
// counting TX beats (writeback data or fill address) and RX fill data beats.
module bus_arbiter #(
   parameter  int num_caches_p     = 2,
   parameter  int block_size_p     = 8,
   parameter  int dma_data_width_p = 2,
   localparam int beats_lp = block_size_p / dma_data_width_p,
   localparam int id_w_lp  = (num_caches_p > 1) ? $clog2(num_caches_p) : 1,
   localparam int cnt_w_lp = $clog2(beats_lp + 1)
) (
   input  logic                    clk_i,
   input  logic                    nreset_i,
   input  logic [num_caches_p-1:0] req_i,
   input  logic [num_caches_p-1:0] req_we_i,
   input  logic                    mem_ready_i,
   input  logic                    mem_valid_i,
   output logic [num_caches_p-1:0] grant_o,
   output logic [id_w_lp-1:0]      grant_id_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [cnt_w_lp-1:0]     beat_cnt_o
);

   typedef enum logic [1:0] {IDLE_S = 2'd0, TX_S = 2'd1, RX_S = 2'd2} state_e;

   state_e                  state_r, state_s;
   logic [id_w_lp-1:0]      ptr_r, ptr_s, owner_r, owner_s;
   logic [id_w_lp-1:0]      pick_s, cand_s, next_ptr_s;
   logic [id_w_lp:0]        sum_s;
   logic                    found_s, hit_s, owner_req_s;
   logic                    we_r, we_s;
   logic [cnt_w_lp-1:0]     beat_r, beat_s;
   logic [num_caches_p-1:0] grant_r, grant_s;
   logic                    busy_r, busy_s, done_r, done_s;

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      sum_s   = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int i = 0; i < num_caches_p; i++) begin
         sum_s   = {1'b0, ptr_r} + (id_w_lp+1)'(i);
         sum_s   = (sum_s >= (id_w_lp+1)'(num_caches_p)) ?
                   (sum_s - (id_w_lp+1)'(num_caches_p)) : sum_s;
         cand_s  = sum_s[id_w_lp-1:0];
         hit_s   = req_i[cand_s] & ~found_s;
         pick_s  = hit_s ? cand_s : pick_s;
         found_s = found_s | hit_s;
      end
   end

   assign owner_req_s = req_i[owner_r];
   assign next_ptr_s  = (owner_r == id_w_lp'(num_caches_p - 1)) ?
                        id_w_lp'(0) : (owner_r + id_w_lp'(1));

   // Next-state and registered-output values for the transaction FSM.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      owner_s = owner_r;
      we_s    = we_r;
      beat_s  = beat_r;
      grant_s = grant_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE_S: begin
            if (found_s) begin
               state_s         = TX_S;
               owner_s         = pick_s;
               we_s            = req_we_i[pick_s];
               beat_s          = '0;
               grant_s         = '0;
               grant_s[pick_s] = 1'b1;
               busy_s          = 1'b1;
            end else begin
               grant_s = '0;
               busy_s  = 1'b0;
            end
         end
         TX_S: begin
            if (owner_req_s && mem_ready_i) begin
               if (!we_r) begin
                  // fill: the single address beat hands over to the data phase
                  state_s = RX_S;
                  beat_s  = '0;
               end else if (beat_r == cnt_w_lp'(beats_lp - 1)) begin
                  state_s = IDLE_S;
                  beat_s  = cnt_w_lp'(beats_lp);
                  ptr_s   = next_ptr_s;
                  owner_s = '0;
                  grant_s = '0;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  beat_s = beat_r + cnt_w_lp'(1);
               end
            end else begin
               beat_s = beat_r;
            end
         end
         RX_S: begin
            if (mem_valid_i) begin
               if (beat_r == cnt_w_lp'(beats_lp - 1)) begin
                  state_s = IDLE_S;
                  beat_s  = cnt_w_lp'(beats_lp);
                  ptr_s   = next_ptr_s;
                  owner_s = '0;
                  grant_s = '0;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  beat_s = beat_r + cnt_w_lp'(1);
               end
            end else begin
               beat_s = beat_r;
            end
         end
         default: begin
            state_s = IDLE_S;
            owner_s = '0;
            beat_s  = '0;
            grant_s = '0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_r <= IDLE_S;
         ptr_r   <= '0;
         owner_r <= '0;
         we_r    <= 1'b0;
         beat_r  <= '0;
         grant_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         owner_r <= owner_s;
         we_r    <= we_s;
         beat_r  <= beat_s;
         grant_r <= grant_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign grant_o    = grant_r;
   assign grant_id_o = owner_r;
   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign beat_cnt_o = beat_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances (N=2/BEATS=4,
// N=4/BEATS=4, N=1/BEATS=1) driven from one linear stimulus sequence.
module tb_bus_arbiter;

   logic clk;
   logic nreset;
   int   checks;
   int   failures;

   logic [1:0] req_a, we_a, grant_a;
   logic       ready_a, valid_a, busy_a, done_a;
   logic [0:0] gid_a;
   logic [2:0] bcnt_a;

   logic [3:0] req_b, we_b, grant_b;
   logic       ready_b, valid_b, busy_b, done_b;
   logic [1:0] gid_b;
   logic [2:0] bcnt_b;

   logic [0:0] req_c, we_c, grant_c, gid_c, bcnt_c;
   logic       ready_c, valid_c, busy_c, done_c;

   bus_arbiter #(.num_caches_p(2), .block_size_p(8), .dma_data_width_p(2)) u_dut_a (
      .clk_i(clk), .nreset_i(nreset), .req_i(req_a), .req_we_i(we_a),
      .mem_ready_i(ready_a), .mem_valid_i(valid_a), .grant_o(grant_a),
      .grant_id_o(gid_a), .busy_o(busy_a), .done_o(done_a), .beat_cnt_o(bcnt_a));

   bus_arbiter #(.num_caches_p(4), .block_size_p(8), .dma_data_width_p(2)) u_dut_b (
      .clk_i(clk), .nreset_i(nreset), .req_i(req_b), .req_we_i(we_b),
      .mem_ready_i(ready_b), .mem_valid_i(valid_b), .grant_o(grant_b),
      .grant_id_o(gid_b), .busy_o(busy_b), .done_o(done_b), .beat_cnt_o(bcnt_b));

   bus_arbiter #(.num_caches_p(1), .block_size_p(2), .dma_data_width_p(2)) u_dut_c (
      .clk_i(clk), .nreset_i(nreset), .req_i(req_c), .req_we_i(we_c),
      .mem_ready_i(ready_c), .mem_valid_i(valid_c), .grant_o(grant_c),
      .grant_id_o(gid_c), .busy_o(busy_c), .done_o(done_c), .beat_cnt_o(bcnt_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] rx_pat;
      int         rx_exp [6];
      rx_pat = 6'b011010;
      rx_exp = '{0, 1, 1, 2, 3, 3};
      checks = 0;
      failures = 0;
      nreset = 1'b0;
      req_a = 2'b00; we_a = 2'b00; ready_a = 1'b0; valid_a = 1'b0;
      req_b = 4'b0000; we_b = 4'b0000; ready_b = 1'b0; valid_b = 1'b0;
      req_c = 1'b0; we_c = 1'b0; ready_c = 1'b0; valid_c = 1'b0;

      // reset state
      tick(); tick();
      check("rst_grant_a", grant_a, 2'b00);
      check("rst_gid_a", gid_a, 1'b0);
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_bcnt_a", bcnt_a, 3'd0);
      check("rst_grant_b", grant_b, 4'b0000);
      check("rst_grant_c", grant_c, 1'b0);
      nreset = 1'b1;

      // N=1, BEATS=1: back-to-back writebacks, then a 1+1 fill
      req_c = 1'b1; we_c = 1'b1; ready_c = 1'b1;
      tick();
      check("c_grant1", grant_c, 1'b1);
      check("c_busy1", busy_c, 1'b1);
      check("c_gid1", gid_c, 1'b0);
      tick();
      check("c_done1", done_c, 1'b1);
      check("c_grant_off1", grant_c, 1'b0);
      tick();
      check("c_regrant", grant_c, 1'b1);
      check("c_done_low", done_c, 1'b0);
      tick();
      check("c_done2", done_c, 1'b1);
      we_c = 1'b0;
      tick();
      check("c_fill_grant", busy_c, 1'b1);
      tick();
      check("c_fill_rx_busy", busy_c, 1'b1);
      check("c_fill_rx_nodone", done_c, 1'b0);
      valid_c = 1'b1;
      tick();
      check("c_fill_done", done_c, 1'b1);
      check("c_fill_bcnt", bcnt_c, 1'b1);
      req_c = 1'b0; valid_c = 1'b0;
      tick();
      check("c_idle", grant_c, 1'b0);

      // N=2 writeback, 4 TX beats
      req_a = 2'b01; we_a = 2'b01; ready_a = 1'b1;
      tick();
      check("wb_grant", grant_a, 2'b01);
      check("wb_busy", busy_a, 1'b1);
      check("wb_bcnt0", bcnt_a, 3'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("wb_bcnt", bcnt_a, 32'(k));
      end
      tick();
      check("wb_done", done_a, 1'b1);
      check("wb_grant_off", grant_a, 2'b00);
      check("wb_busy_off", busy_a, 1'b0);
      req_a = 2'b00;
      tick();
      check("wb_done_pulse", done_a, 1'b0);

      // fill with gapped mem_valid; pointer now at 1
      req_a = 2'b11; we_a = 2'b00; ready_a = 1'b1; valid_a = 1'b0;
      tick();
      check("fill_grant", grant_a, 2'b10);
      check("fill_gid", gid_a, 1'b1);
      valid_a = 1'b1;
      tick();
      check("fill_rx_bcnt0", bcnt_a, 3'd0);
      for (int k = 0; k < 6; k++) begin
         valid_a = rx_pat[k];
         tick();
         check("fill_rx_bcnt", bcnt_a, 32'(rx_exp[k]));
         check("fill_rx_grant", grant_a, 2'b10);
      end
      valid_a = 1'b1;
      tick();
      check("fill_done", done_a, 1'b1);
      check("fill_grant_off", grant_a, 2'b00);

      // owner 0 writeback with toggling ready, late we change, other request
      req_a = 2'b01; we_a = 2'b01; ready_a = 1'b0; valid_a = 1'b0;
      tick();
      check("rr_next_grant", grant_a, 2'b01);
      check("rr_next_gid", gid_a, 1'b0);
      req_a = 2'b11; we_a = 2'b00;
      tick();
      check("tog_bcnt_a", bcnt_a, 3'd0);
      ready_a = 1'b1;
      tick();
      check("tog_bcnt_b", bcnt_a, 3'd1);
      ready_a = 1'b0;
      tick();
      check("tog_bcnt_c", bcnt_a, 3'd1);
      ready_a = 1'b1;
      tick();
      check("tog_bcnt_d", bcnt_a, 3'd2);
      req_a = 2'b10;
      tick();
      check("tog_noreq_bcnt", bcnt_a, 3'd2);
      check("tog_hold_grant", grant_a, 2'b01);
      req_a = 2'b11;
      tick();
      check("tog_bcnt_e", bcnt_a, 3'd3);
      check("tog_grant", grant_a, 2'b01);
      tick();
      check("tog_done", done_a, 1'b1);
      check("tog_grant_off", grant_a, 2'b00);
      req_a = 2'b00; ready_a = 1'b0;

      // N=4 all requesting: order 0,1,2,3,0
      req_b = 4'b1111; we_b = 4'b1111; ready_b = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("rr4_grant", grant_b, 32'(4'b0001 << (i % 4)));
         check("rr4_gid", gid_b, 32'(i % 4));
         repeat (4) tick();
         check("rr4_done", done_b, 1'b1);
         check("rr4_gap", grant_b, 4'b0000);
         if (i == 4) req_b = 4'b0000;
         tick();
      end
      check("rr4_idle", grant_b, 4'b0000);

      // reset during RX at beat 2 aborts without done
      req_b = 4'b0001; we_b = 4'b0000; ready_b = 1'b1; valid_b = 1'b1;
      tick();
      check("rx_rst_grant", grant_b, 4'b0001);
      tick(); tick(); tick();
      check("rx_rst_bcnt2", bcnt_b, 3'd2);
      nreset = 1'b0;
      tick();
      check("rx_rst_grant0", grant_b, 4'b0000);
      check("rx_rst_busy0", busy_b, 1'b0);
      check("rx_rst_done0", done_b, 1'b0);
      check("rx_rst_bcnt0", bcnt_b, 3'd0);
      check("rx_rst_gid0", gid_b, 2'd0);
      nreset = 1'b1; req_b = 4'b0110; valid_b = 1'b0;
      tick();
      check("post_rst_grant", grant_b, 4'b0010);
      check("post_rst_gid", gid_b, 2'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
